// File: rtl/ysyx_22050612_lsu.sv
// Load/store unit: aligns byte/half/word/double accesses onto a 64-bit
// bus, splitting accesses that cross an 8-byte boundary into two beats.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake from execute stage
//   req_wen/addr/wdata/size/signed   request fields, latched on accept
//   resp_valid/resp_rdata        one-cycle completion pulse and load data
//   mem_valid/mem_ready          bus handshake
//   mem_wen/addr/wdata/wmask     aligned bus request, lane-positioned
//   mem_rdata                    bus read data
module ysyx_22050612_lsu #(
    parameter int AW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wen,
    input  logic [AW-1:0] req_addr,
    input  logic [63:0]   req_wdata,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    output logic          resp_valid,
    output logic [63:0]   resp_rdata,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic [63:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [AW-1:0] r_addr;
    logic          r_wen;
    logic [63:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [63:0]   lo;
    logic [63:0]   hi;

    logic [2:0]    off;
    logic [5:0]    sh;
    logic [7:0]    bmask;
    logic [15:0]   mask16;
    logic [127:0]  wdata128;
    logic          split;
    logic [AW-1:0] base;
    logic          hs;
    logic [63:0]   rd;
    logic [63:0]   ext;

    assign off      = r_addr[2:0];
    assign sh       = {off, 3'b000};
    assign mask16   = {8'h00, bmask} << off;
    assign wdata128 = {64'h0, r_wdata} << sh;
    assign split    = |mask16[15:8];
    assign base     = {r_addr[AW-1:3], 3'b000};
    assign hs       = mem_valid && mem_ready;
    // The requested bytes start at lane 'off' of the two-beat window.
    assign rd       = 64'({hi, lo} >> sh);

    always_comb begin
        bmask = 8'hFF;
        ext   = rd;
        unique case (r_size)
            2'd0: begin
                bmask = 8'h01;
                ext   = {{56{r_signed & rd[7]}}, rd[7:0]};
            end
            2'd1: begin
                bmask = 8'h03;
                ext   = {{48{r_signed & rd[15]}}, rd[15:0]};
            end
            2'd2: begin
                bmask = 8'h0F;
                ext   = {{32{r_signed & rd[31]}}, rd[31:0]};
            end
            default: begin
                bmask = 8'hFF;
                ext   = rd;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            r_addr   <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            lo       <= '0;
            hi       <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                r_addr   <= req_addr;
                r_wen    <= req_wen;
                r_wdata  <= req_wdata;
                r_size   <= req_size;
                r_signed <= req_signed;
            end
            if (state == BEAT0 && hs) lo <= mem_rdata;
            if (state == BEAT1 && hs) hi <= mem_rdata;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = BEAT0;
            end
            BEAT0: begin
                mem_valid = 1'b1;
                mem_wen   = r_wen;
                mem_addr  = base;
                if (r_wen) begin
                    mem_wdata = wdata128[63:0];
                    mem_wmask = mask16[7:0];
                end
                if (hs) state_nx = split ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_valid = 1'b1;
                mem_wen   = r_wen;
                mem_addr  = base + AW'(8);
                if (r_wen) begin
                    mem_wdata = wdata128[127:64];
                    mem_wmask = mask16[15:8];
                end
                if (hs) state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_wen ? 64'h0 : ext;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
